// File: rtl/array_watch_pkg.sv
// Shared constants and FSM encoding for the array_watch block.
package array_watch_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_ROWS   = 4;
  localparam int DEF_COL_LO = 1;
  localparam int DEF_COL_HI = 2;
  localparam int COORD_W    = 8;
  localparam int CNT_W      = 8;

endpackage

// File: rtl/array_watch_decode.sv
// Range check of a [row][col] coordinate and its row-major flat word index.
module array_watch_decode
  import array_watch_pkg::*;
#(
  parameter int ROWS   = DEF_ROWS,
  parameter int COL_LO = DEF_COL_LO,
  parameter int COL_HI = DEF_COL_HI,
  parameter int IDX_W  = 3
) (
  input  logic [COORD_W-1:0] row_i,
  input  logic [COORD_W-1:0] col_i,
  output logic               in_range_o,
  output logic [IDX_W-1:0]   idx_o
);

  localparam int NCOLS = COL_HI - COL_LO + 1;

  logic [31:0] row_w;
  logic [31:0] col_w;

  assign row_w = 32'(row_i);
  assign col_w = 32'(col_i);

  assign in_range_o = (row_w < 32'(ROWS)) && (col_w >= 32'(COL_LO)) && (col_w <= 32'(COL_HI));

  // Out-of-range coordinates map to word 0; callers gate every use with in_range_o.
  assign idx_o = in_range_o ? IDX_W'(row_w * 32'(NCOLS) + col_w - 32'(COL_LO)) : '0;

endmodule

// File: rtl/array_watch.sv
// Small 2-D register array with write/read ports, a sweeping clear and a watched-bit change counter.
module array_watch
  import array_watch_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ROWS   = DEF_ROWS,
  parameter int COL_LO = DEF_COL_LO,
  parameter int COL_HI = DEF_COL_HI
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [COORD_W-1:0]       wr_row,
  input  logic [COORD_W-1:0]       wr_col,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [COORD_W-1:0]       rd_row,
  input  logic [COORD_W-1:0]       rd_col,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic                     rd_oob,
  input  logic [COORD_W-1:0]       watch_row,
  input  logic [COORD_W-1:0]       watch_col,
  input  logic [$clog2(WIDTH)-1:0] watch_bit,
  output logic [CNT_W-1:0]         watch_cnt,
  output logic [CNT_W-1:0]         oob_cnt
);

  localparam int NCOLS = COL_HI - COL_LO + 1;
  localparam int DEPTH = ROWS * NCOLS;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];

  state_e           state_q, state_d;
  logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
  logic             clr_wipe;

  logic             w_in, r_in, watch_in;
  logic [IDX_W-1:0] w_idx, r_idx, watch_idx;

  logic             wr_acc;
  logic             wr_store;
  logic             wr_drop;

  logic [WIDTH-1:0] rd_data_q;
  logic             rd_valid_q;
  logic             rd_oob_q;
  logic [CNT_W-1:0] watch_cnt_q;
  logic [CNT_W-1:0] oob_cnt_q;

  logic [WIDTH-1:0] watch_old;
  logic [WIDTH-1:0] watch_new;
  logic             watch_hit;

  array_watch_decode #(
    .ROWS(ROWS), .COL_LO(COL_LO), .COL_HI(COL_HI), .IDX_W(IDX_W)
  ) u_dec_wr (
    .row_i(wr_row), .col_i(wr_col), .in_range_o(w_in), .idx_o(w_idx)
  );

  array_watch_decode #(
    .ROWS(ROWS), .COL_LO(COL_LO), .COL_HI(COL_HI), .IDX_W(IDX_W)
  ) u_dec_rd (
    .row_i(rd_row), .col_i(rd_col), .in_range_o(r_in), .idx_o(r_idx)
  );

  array_watch_decode #(
    .ROWS(ROWS), .COL_LO(COL_LO), .COL_HI(COL_HI), .IDX_W(IDX_W)
  ) u_dec_watch (
    .row_i(watch_row), .col_i(watch_col), .in_range_o(watch_in), .idx_o(watch_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // A clr pulse takes priority over a write presented in the same IDLE cycle.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    wr_ready  = 1'b0;
    clr_wipe  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        wr_ready = !clr;
        if (clr) begin
          state_d   = ST_CLEAR;
          clr_idx_d = '0;
        end
      end
      ST_CLEAR: begin
        clr_wipe  = 1'b1;
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == LAST_IDX) begin
          state_d   = ST_IDLE;
          clr_idx_d = '0;
        end
      end
    endcase
  end

  assign wr_acc   = wr_valid && wr_ready;
  assign wr_store = wr_acc && w_in;
  assign wr_drop  = wr_acc && !w_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (clr_wipe) begin
      mem_q[clr_idx_q] <= '0;
    end else if (wr_store) begin
      mem_q[w_idx] <= wr_data;
    end
  end

  // Read samples the array before this edge's update, giving read-before-write.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_oob_q   <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_en;
      rd_oob_q   <= rd_en && !r_in;
      rd_data_q  <= (rd_en && r_in) ? mem_q[r_idx] : '0;
    end
  end

  // Next value of the watched word; writes and the clear sweep are mutually exclusive.
  always_comb begin
    watch_old = mem_q[watch_idx];
    watch_new = watch_old;
    if (clr_wipe && (clr_idx_q == watch_idx)) begin
      watch_new = '0;
    end else if (wr_store && (w_idx == watch_idx)) begin
      watch_new = wr_data;
    end
  end

  assign watch_hit = watch_in && (watch_old[watch_bit] != watch_new[watch_bit]);

  always_ff @(posedge clk) begin
    if (rst) begin
      watch_cnt_q <= '0;
      oob_cnt_q   <= '0;
    end else begin
      if (watch_hit) begin
        watch_cnt_q <= watch_cnt_q + 1'b1;
      end
      if (wr_drop) begin
        oob_cnt_q <= oob_cnt_q + 1'b1;
      end
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign rd_oob    = rd_oob_q;
  assign watch_cnt = watch_cnt_q;
  assign oob_cnt   = oob_cnt_q;

endmodule
